controlador_montacargas: RTL and testbench
==========================================

# controlador_montacargas

Sequencing controller for the three-floor freight lift. Latches floor calls, schedules cabin travel with a same-direction-first (SCAN) policy, and drives the hoist motor and door. Produces the 3-bit floor code consumed by the downstream 7-segment floor decoder: 001/010/011 for floors 1–3, 111 shown as "A" during alarm. Clocked at the system tick (1 kHz nominal, 1 cycle = 1 ms).

## Interface
- TICKS_POR_PISO, 2000: cycles of motor run per one-floor move; must be ≥1.
- TICKS_PUERTA, 3000: cycles the door stays open per stop; must be ≥1.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- llamada  in  3  floor call request; bit0 = floor 1, bit2 = floor 3; level, sampled every cycle.
- alarma  in  1  emergency stop, level.
- pisoEnBinario  out  3  floor code: 001, 010, 011, or 111 in alarm; never 000 after reset.
- motorSubir  out  1  hoist up.
- motorBajar  out  1  hoist down; never high together with motorSubir.
- puertaAbierta  out  1  door open command.
- pendientes  out  3  latched, not-yet-served calls.

## Operation
- All outputs are registered. Reset values: pisoEnBinario=001, motorSubir=0, motorBajar=0, puertaAbierta=0, pendientes=000, state REPOSO, direction = up, timer cleared.
- Call latch: every cycle, pendientes <= (pendientes | llamada) & ~servido.
  - servido is the current-floor bit when the FSM enters PUERTA, or while in PUERTA.
  - All bits are forced to 000 in ALARMA.
- States: REPOSO, SUBIENDO, BAJANDO, PUERTA, ALARMA.
- REPOSO:
  - If the current-floor bit is pending, go to PUERTA.
  - Otherwise, if pending calls exist both above and below, continue in the stored direction.
  - Otherwise go toward the only side with calls (SUBIENDO or BAJANDO).
  - Otherwise stay in REPOSO.
- SUBIENDO / BAJANDO:
  - The motor output is high for the whole state.
  - Each TICKS_POR_PISO cycles, the floor goes up or down by one.
  - On arrival, if the new floor is pending, go to PUERTA.
  - Otherwise, if calls remain further in the same direction, keep moving with the timer reloaded.
  - Otherwise go to REPOSO.
  - Floor never leaves 1..3. Floor 3 stops up travel and floor 1 stops down travel, whatever the pendientes contents.
- PUERTA:
  - puertaAbierta is high for exactly TICKS_PUERTA cycles, then the FSM goes to REPOSO.
  - A call for the current floor arriving during PUERTA reloads the door timer and is not latched.
- Direction register: updated on every entry to SUBIENDO/BAJANDO.
- ALARMA:
  - Entered from any state when alarma=1.
  - Motors and door are 0. pisoEnBinario=111. pendientes cleared. New calls are ignored.
  - The FSM stays in ALARMA while alarma=1. It leaves to REPOSO on the first cycle alarma=0.
  - pisoEnBinario then shows the last floor reached. Partial travel is discarded.
- Reset has priority over alarma. alarma has priority over every other transition.

## Timing
- llamada high at edge k: pendientes bit set after edge k.
- From REPOSO, the motor (or door) output goes high after edge k+1.
- One-floor trip: the motor output is high for TICKS_POR_PISO cycles. pisoEnBinario updates on the same edge the motor drops or the next leg starts.
- Multi-floor trip: the motor stays high continuously, 2×TICKS_POR_PISO cycles for floors 1→3.
- Door: puertaAbierta rises on the edge the motor falls and stays high TICKS_PUERTA cycles.
- Back-to-back services: there is one REPOSO cycle between door close and next motion.
- alarma high at edge k: all outputs take alarm values after edge k.

## Structure
- Package montacargas_pkg holds:
  - the state enum;
  - floor code constants PISO_1=3'b001, PISO_2=3'b010, PISO_3=3'b011, CODIGO_ALARMA=3'b111, APAGADO=3'b000;
  - the direction constants.
  The display decoder uses the same constants.
- Sub-module temporizador_montacargas: a loadable down-counter.
  - Width $clog2(max(TICKS_POR_PISO, TICKS_PUERTA)+1).
  - Inputs: load, value. Output: fin, a one-cycle pulse when the count reaches 0.
  - One instance, shared by the travel and door phases.

## Test plan
Run with TICKS_POR_PISO=4, TICKS_PUERTA=3.
- Reset, idle 10 cycles: pisoEnBinario=001, all other outputs 0, pendientes=000.
- Single cycle llamada=100 at floor 1: motorSubir high 8 cycles, pisoEnBinario 001→010→011, then puertaAbierta high 3 cycles, then pendientes=000.
- At floor 2, idle, stored direction up, llamada=101 in one cycle: the cabin serves floor 3 first, then floor 1.
- Call for floor 2 held during PUERTA at floor 2: puertaAbierta stays high until 3 cycles after the call drops; pendientes[1] stays 0.
- alarma asserted mid-travel 1→2 for 5 cycles: next cycle, motors=0 and pisoEnBinario=111 with pendientes=000. After release, REPOSO with pisoEnBinario=001.
- reset and alarma asserted together: reset values are applied, not alarm values.

Source files
------------

// File: rtl/montacargas_pkg.sv
// Shared types, floor codes and scheduling helpers for the three-floor freight lift.
// The floor code doubles as the floor number (1..3), so arithmetic on it moves the cabin.
package montacargas_pkg;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        PUERTA   = 3'd3,
        ALARMA   = 3'd4
    } estado_t;

    localparam logic [2:0] PISO_1        = 3'b001;
    localparam logic [2:0] PISO_2        = 3'b010;
    localparam logic [2:0] PISO_3        = 3'b011;
    localparam logic [2:0] CODIGO_ALARMA = 3'b111;
    localparam logic [2:0] APAGADO       = 3'b000;

    localparam logic DIR_SUBIR = 1'b1;
    localparam logic DIR_BAJAR = 1'b0;

    function automatic logic [2:0] mascara_piso(input logic [2:0] piso);
        logic [2:0] m;
        case (piso)
            PISO_1:  m = 3'b001;
            PISO_2:  m = 3'b010;
            PISO_3:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] mascara_arriba(input logic [2:0] piso);
        logic [2:0] m;
        case (piso)
            PISO_1:  m = 3'b110;
            PISO_2:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] mascara_abajo(input logic [2:0] piso);
        logic [2:0] m;
        case (piso)
            PISO_2:  m = 3'b001;
            PISO_3:  m = 3'b011;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/controlador_montacargas_if.sv
// Call/alarm inputs and motor/door/display outputs of the lift controller.
interface controlador_montacargas_if;
    logic [2:0] llamada;
    logic       alarma;
    logic [2:0] pisoEnBinario;
    logic       motorSubir;
    logic       motorBajar;
    logic       puertaAbierta;
    logic [2:0] pendientes;

    modport master (
        output llamada, alarma,
        input  pisoEnBinario, motorSubir, motorBajar, puertaAbierta, pendientes
    );

    modport slave (
        input  llamada, alarma,
        output pisoEnBinario, motorSubir, motorBajar, puertaAbierta, pendientes
    );
endinterface

// File: rtl/temporizador_montacargas.sv
// Loadable down-counter shared by the travel and door phases.
// fin flags the cycle whose closing edge brings the count to zero.
module temporizador_montacargas #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ANCHO-1:0] value,
    output logic             fin
);
    logic [ANCHO-1:0] cuenta_r;

    // count register: load wins, otherwise decrement until zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_r <= '0;
        end else if (load) begin
            cuenta_r <= value;
        end else if (cuenta_r != '0) begin
            cuenta_r <= cuenta_r - ANCHO'(1);
        end else begin
            cuenta_r <= cuenta_r;
        end
    end

    assign fin = (cuenta_r == ANCHO'(1));
endmodule

// File: rtl/controlador_montacargas.sv
// SCAN sequencing controller for the three-floor freight lift: latches calls,
// schedules travel, drives hoist and door, and reports the floor code.
module controlador_montacargas
    import montacargas_pkg::*;
#(
    parameter int TICKS_POR_PISO = 2000,
    parameter int TICKS_PUERTA   = 3000
) (
    input  logic                             clk,
    input  logic                             reset,
    controlador_montacargas_if.slave         bus
);
    localparam int MAX_TICKS = (TICKS_POR_PISO > TICKS_PUERTA) ? TICKS_POR_PISO : TICKS_PUERTA;
    localparam int ANCHO     = $clog2(MAX_TICKS + 1);
    localparam logic [ANCHO-1:0] CARGA_PISO   = ANCHO'(TICKS_POR_PISO);
    localparam logic [ANCHO-1:0] CARGA_PUERTA = ANCHO'(TICKS_PUERTA);

    estado_t          estado_r, estado_s;
    logic [2:0]       piso_r, piso_s, llegada_s, mas_alla_s;
    logic             dir_r, dir_s;
    logic [2:0]       pend_r, pend_s, servido_s;
    logic             carga_s, fin_s, hay_arriba_s, hay_abajo_s;
    logic [ANCHO-1:0] valor_s;
    logic [2:0]       codigo_r;
    logic             subir_r, bajar_r, puerta_r;

    assign hay_arriba_s = |(pend_r & mascara_arriba(piso_r));
    assign hay_abajo_s  = |(pend_r & mascara_abajo(piso_r));

    // next floor on arrival (clamped to 1..3) and the calls still ahead of it
    always_comb begin
        llegada_s  = piso_r;
        mas_alla_s = 3'b000;
        if (estado_r == SUBIENDO) begin
            llegada_s  = (piso_r == PISO_3) ? piso_r : piso_r + 3'd1;
            mas_alla_s = mascara_arriba(llegada_s);
        end else if (estado_r == BAJANDO) begin
            llegada_s  = (piso_r == PISO_1) ? piso_r : piso_r - 3'd1;
            mas_alla_s = mascara_abajo(llegada_s);
        end else begin
            llegada_s  = piso_r;
            mas_alla_s = 3'b000;
        end
    end

    // scheduling decisions, timer control and call-latch update
    always_comb begin
        estado_s  = estado_r;
        piso_s    = piso_r;
        dir_s     = dir_r;
        servido_s = 3'b000;
        carga_s   = 1'b0;
        valor_s   = '0;
        if (bus.alarma) begin
            estado_s = ALARMA;
            carga_s  = 1'b1;
        end else begin
            case (estado_r)
                REPOSO: begin
                    if (|(pend_r & mascara_piso(piso_r))) begin
                        estado_s  = PUERTA;
                        carga_s   = 1'b1;
                        valor_s   = CARGA_PUERTA;
                        servido_s = mascara_piso(piso_r);
                    end else if (hay_arriba_s && hay_abajo_s) begin
                        estado_s = (dir_r == DIR_SUBIR) ? SUBIENDO : BAJANDO;
                        carga_s  = 1'b1;
                        valor_s  = CARGA_PISO;
                    end else if (hay_arriba_s) begin
                        estado_s = SUBIENDO;
                        dir_s    = DIR_SUBIR;
                        carga_s  = 1'b1;
                        valor_s  = CARGA_PISO;
                    end else if (hay_abajo_s) begin
                        estado_s = BAJANDO;
                        dir_s    = DIR_BAJAR;
                        carga_s  = 1'b1;
                        valor_s  = CARGA_PISO;
                    end else begin
                        estado_s = REPOSO;
                    end
                end
                SUBIENDO, BAJANDO: begin
                    if (fin_s) begin
                        piso_s = llegada_s;
                        if (|(pend_r & mascara_piso(llegada_s))) begin
                            estado_s  = PUERTA;
                            carga_s   = 1'b1;
                            valor_s   = CARGA_PUERTA;
                            servido_s = mascara_piso(llegada_s);
                        end else if (|(pend_r & mas_alla_s)) begin
                            carga_s = 1'b1;
                            valor_s = CARGA_PISO;
                        end else begin
                            estado_s = REPOSO;
                        end
                    end else begin
                        piso_s = piso_r;
                    end
                end
                PUERTA: begin
                    servido_s = mascara_piso(piso_r);
                    // a fresh call for this floor keeps the door open
                    if (|(bus.llamada & servido_s)) begin
                        carga_s = 1'b1;
                        valor_s = CARGA_PUERTA;
                    end else if (fin_s) begin
                        estado_s = REPOSO;
                    end else begin
                        estado_s = PUERTA;
                    end
                end
                ALARMA:  estado_s = REPOSO;
                default: estado_s = REPOSO;
            endcase
        end
        if (bus.alarma || (estado_r == ALARMA)) begin
            pend_s = 3'b000;
        end else begin
            pend_s = (pend_r | bus.llamada) & ~servido_s;
        end
    end

    temporizador_montacargas #(.ANCHO(ANCHO)) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .load  (carga_s),
        .value (valor_s),
        .fin   (fin_s)
    );

    // state, floor, direction and call registers with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= REPOSO;
            piso_r   <= PISO_1;
            dir_r    <= DIR_SUBIR;
            pend_r   <= 3'b000;
            codigo_r <= PISO_1;
            subir_r  <= 1'b0;
            bajar_r  <= 1'b0;
            puerta_r <= 1'b0;
        end else begin
            estado_r <= estado_s;
            piso_r   <= piso_s;
            dir_r    <= dir_s;
            pend_r   <= pend_s;
            codigo_r <= (estado_s == ALARMA) ? CODIGO_ALARMA : piso_s;
            subir_r  <= (estado_s == SUBIENDO);
            bajar_r  <= (estado_s == BAJANDO);
            puerta_r <= (estado_s == PUERTA);
        end
    end

    assign bus.pisoEnBinario = codigo_r;
    assign bus.motorSubir    = subir_r;
    assign bus.motorBajar    = bajar_r;
    assign bus.puertaAbierta = puerta_r;
    assign bus.pendientes    = pend_r;
endmodule

// File: tb/tb_controlador_montacargas.sv
// Self-checking bench: directed lift scenarios plus random calls/alarms/resets,
// compared every cycle against a floor/countdown reference model.
module tb_controlador_montacargas;
    localparam int TPP = 4;
    localparam int TP  = 3;
    localparam int M_REPOSO = 0, M_MOVIENDO = 1, M_PUERTA = 2, M_ALARMA = 3;

    logic clk;
    logic reset;
    controlador_montacargas_if bus ();

    controlador_montacargas #(.TICKS_POR_PISO(TPP), .TICKS_PUERTA(TP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectores = 0;
    int errores  = 0;

    int         m_modo, m_piso, m_dir, m_quedan;
    logic [3:1] m_pend;

    task automatic comprobar(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        vectores++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, esp, $time);
        end
    endtask

    function automatic bit hay_mas(input int piso, input int dir);
        bit r = 1'b0;
        for (int f = 1; f <= 3; f++)
            if (m_pend[f] && ((dir > 0) ? (f > piso) : (f < piso))) r = 1'b1;
        return r;
    endfunction

    task automatic modelo_paso(input logic [2:0] ll, input logic al, input logic rs);
        logic [3:1] lln;
        int servido;
        bit desde_alarma;
        lln = ll;
        servido = 0;
        desde_alarma = 1'b0;
        if (rs) begin
            m_modo = M_REPOSO; m_piso = 1; m_dir = 1; m_pend = 3'b000; m_quedan = 0;
        end else if (al) begin
            m_modo = M_ALARMA; m_pend = 3'b000; m_quedan = 0;
        end else begin
            case (m_modo)
                M_ALARMA: begin m_modo = M_REPOSO; desde_alarma = 1'b1; end
                M_REPOSO: begin
                    if (m_pend[m_piso]) begin
                        m_modo = M_PUERTA; m_quedan = TP; servido = m_piso;
                    end else if (hay_mas(m_piso, 1) && hay_mas(m_piso, -1)) begin
                        m_modo = M_MOVIENDO; m_quedan = TPP;
                    end else if (hay_mas(m_piso, 1)) begin
                        m_modo = M_MOVIENDO; m_dir = 1; m_quedan = TPP;
                    end else if (hay_mas(m_piso, -1)) begin
                        m_modo = M_MOVIENDO; m_dir = -1; m_quedan = TPP;
                    end
                end
                M_MOVIENDO: begin
                    m_quedan--;
                    if (m_quedan == 0) begin
                        m_piso += m_dir;
                        if (m_pend[m_piso]) begin
                            m_modo = M_PUERTA; m_quedan = TP; servido = m_piso;
                        end else if (hay_mas(m_piso, m_dir)) m_quedan = TPP;
                        else m_modo = M_REPOSO;
                    end
                end
                default: begin
                    servido = m_piso;
                    if (lln[m_piso]) m_quedan = TP;
                    else begin
                        m_quedan--;
                        if (m_quedan == 0) m_modo = M_REPOSO;
                    end
                end
            endcase
            if (!desde_alarma)
                for (int f = 1; f <= 3; f++) m_pend[f] = (m_pend[f] | lln[f]) & (f != servido);
        end
    endtask

    function automatic logic [8:0] esperado();
        logic [2:0] piso = (m_modo == M_ALARMA) ? 3'b111 : 3'(m_piso);
        return {piso, (m_modo == M_MOVIENDO) && (m_dir > 0), (m_modo == M_MOVIENDO) && (m_dir < 0),
                m_modo == M_PUERTA, m_pend};
    endfunction

    task automatic ciclo(input logic [2:0] ll, input logic al, input logic rs);
        @(negedge clk);
        bus.llamada = ll;
        bus.alarma  = al;
        reset       = rs;
        @(posedge clk);
        modelo_paso(ll, al, rs);
        #1;
        comprobar("salidas", {bus.pisoEnBinario, bus.motorSubir, bus.motorBajar,
                              bus.puertaAbierta, bus.pendientes}, esperado());
    endtask

    initial begin
        int pisos_puerta[$];
        logic puerta_prev;
        int espera, alarma_resto;
        logic [2:0] ll;
        logic al, rs;

        bus.llamada = 3'b000;
        bus.alarma  = 1'b0;
        reset       = 1'b1;

        // reset, then idle
        repeat (2) ciclo(3'b000, 1'b0, 1'b1);
        repeat (10) ciclo(3'b000, 1'b0, 1'b0);
        comprobar("reposo_piso", bus.pisoEnBinario, 3'b001);

        // floor 1 -> 3 in one continuous run
        ciclo(3'b100, 1'b0, 1'b0);
        repeat (20) ciclo(3'b000, 1'b0, 1'b0);
        comprobar("viaje_1a3_piso", bus.pisoEnBinario, 3'b011);
        comprobar("viaje_1a3_pend", bus.pendientes, 3'b000);

        // at floor 2 heading up, calls on both sides: floor 3 first
        ciclo(3'b000, 1'b0, 1'b1);
        ciclo(3'b010, 1'b0, 1'b0);
        repeat (15) ciclo(3'b000, 1'b0, 1'b0);
        ciclo(3'b101, 1'b0, 1'b0);
        puerta_prev = bus.puertaAbierta;
        for (int i = 0; i < 40; i++) begin
            ciclo(3'b000, 1'b0, 1'b0);
            if (bus.puertaAbierta && !puerta_prev) pisos_puerta.push_back(int'(bus.pisoEnBinario));
            puerta_prev = bus.puertaAbierta;
        end
        comprobar("scan_primero", (pisos_puerta.size() > 0) ? 16'(pisos_puerta[0]) : 16'd0, 16'd3);
        comprobar("scan_segundo", (pisos_puerta.size() > 1) ? 16'(pisos_puerta[1]) : 16'd0, 16'd1);

        // call for floor 2 held while its door is open
        ciclo(3'b010, 1'b0, 1'b0);
        espera = 0;
        while (!bus.puertaAbierta && espera < 20) begin
            ciclo(3'b000, 1'b0, 1'b0);
            espera++;
        end
        comprobar("espera_puerta", 16'(bus.puertaAbierta), 16'd1);
        for (int i = 0; i < 5; i++) begin
            ciclo(3'b010, 1'b0, 1'b0);
            comprobar("pend2_en_puerta", 16'(bus.pendientes[1]), 16'd0);
        end
        repeat (2) ciclo(3'b000, 1'b0, 1'b0);
        comprobar("puerta_tras_soltar", 16'(bus.puertaAbierta), 16'd1);
        repeat (8) ciclo(3'b000, 1'b0, 1'b0);

        // alarm in the middle of a 1 -> 2 trip
        ciclo(3'b000, 1'b0, 1'b1);
        ciclo(3'b010, 1'b0, 1'b0);
        repeat (2) ciclo(3'b000, 1'b0, 1'b0);
        repeat (5) ciclo(3'b000, 1'b1, 1'b0);
        comprobar("alarma_codigo", bus.pisoEnBinario, 3'b111);
        repeat (5) ciclo(3'b000, 1'b0, 1'b0);
        comprobar("tras_alarma_piso", bus.pisoEnBinario, 3'b001);

        // reset outranks alarm
        ciclo(3'b111, 1'b1, 1'b1);
        comprobar("reset_sobre_alarma", bus.pisoEnBinario, 3'b001);

        // random calls, alarm bursts and occasional resets
        alarma_resto = 0;
        for (int i = 0; i < 3000; i++) begin
            ll = 3'b000;
            for (int b = 0; b < 3; b++) ll[b] = ($urandom_range(0, 9) == 0);
            if (alarma_resto > 0) alarma_resto--;
            else if ($urandom_range(0, 149) == 0) alarma_resto = $urandom_range(1, 6);
            al = (alarma_resto > 0);
            rs = ($urandom_range(0, 699) == 0);
            ciclo(ll, al, rs);
            comprobar("motores_exclusivos", 16'(bus.motorSubir & bus.motorBajar), 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
        $finish;
    end
endmodule
